alu_op_issuer: RTL and testbench

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_issue_skid.sv | 82 ++++++++
 rtl/alu_op_issuer.sv | 141 ++++++++++++++
 tb/tb_alu_op_issuer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS ALU operation issuer: ALU control codes,
// opcode/funct encodings and the decoded-entry record carried by the skid buffer.
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] CtrlAnd     = 4'b0000;
    localparam logic [3:0] CtrlOr      = 4'b0001;
    localparam logic [3:0] CtrlAddu    = 4'b0010;
    localparam logic [3:0] CtrlXor     = 4'b0011;
    localparam logic [3:0] CtrlNor     = 4'b0100;
    localparam logic [3:0] CtrlSubu    = 4'b0110;
    localparam logic [3:0] CtrlSlt     = 4'b0111;
    localparam logic [3:0] CtrlSll     = 4'b1000;
    localparam logic [3:0] CtrlSrl     = 4'b1001;
    localparam logic [3:0] CtrlAdd     = 4'b1011;
    localparam logic [3:0] CtrlSub     = 4'b1100;
    localparam logic [3:0] CtrlIllegal = 4'b1111;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;

    // R-type funct codes
    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;

    typedef struct packed {
        logic [3:0]  control;
        logic [31:0] operand0;
        logic [31:0] operand1;
        logic [4:0]  dest;
        logic        illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry skid buffer. The head register drives the output directly, so the
// presented entry only changes on a pop or when loading into an empty buffer.
// push_ready_o is registered and depends only on occupancy.
module alu_issue_skid #(
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  entry_t push_data_i,
    output logic   push_ready_o,
    output logic   pop_valid_o,
    input  logic   pop_ready_i,
    output entry_t pop_data_o
);

    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;
    logic       push, pop;

    assign push = push_i && ready_q;
    assign pop  = (cnt_q != 2'd0) && pop_ready_i;

    // Next-state for occupancy and the two entry slots.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = push_data_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = push_data_i;
                end else if (push) begin
                    tail_d = push_data_i;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data_i;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
            default: cnt_d = 2'd0;
        endcase
        ready_d = (cnt_d != 2'd2);
    end

    // Buffer state; reset discards everything and holds off input until the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign push_ready_o = ready_q;
    assign pop_valid_o  = (cnt_q != 2'd0);
    assign pop_data_o   = head_q;

endmodule

// File: rtl/alu_op_issuer.sv
// MIPS ALU operation issuer: decodes an instruction plus register operands into
// an ALU control code and operand pair, and issues it through a 2-entry skid buffer.
// Optional: define ALU_ISSUER_LOGIC_EXT_EN to decode xor, nor and xori.
module alu_op_issuer
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  control,
    output logic [31:0] operand0,
    output logic [31:0] operand1,
    output logic [4:0]  dest,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rt_f, rd_f, shamt;
    logic [31:0] simm, zimm;
    logic        ok;
    logic [3:0]  ctrl;
    logic [31:0] op0, op1;
    logic [4:0]  dst;
    alu_entry_t  dec, head;
    logic [7:0]  illegal_cnt_q, illegal_cnt_d;
    logic        accept;
    logic        unused_rs_field;

    assign opcode = instr[31:26];
    assign rt_f   = instr[20:16];
    assign rd_f   = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign simm   = {{16{instr[15]}}, instr[15:0]};
    assign zimm   = {16'h0000, instr[15:0]};
    // The rs index is resolved by the register file; only its data is used here.
    assign unused_rs_field = ^instr[25:21];

    // Combinational decode of the incoming instruction into an ALU entry.
    always_comb begin
        ok   = 1'b1;
        ctrl = CtrlIllegal;
        op0  = rs_data;
        op1  = rt_data;
        dst  = rd_f;
        case (opcode)
            OpRtype: begin
                case (funct)
                    FnAdd:  ctrl = CtrlAdd;
                    FnAddu: ctrl = CtrlAddu;
                    FnSub:  ctrl = CtrlSub;
                    FnSubu: ctrl = CtrlSubu;
                    FnAnd:  ctrl = CtrlAnd;
                    FnOr:   ctrl = CtrlOr;
`ifdef ALU_ISSUER_LOGIC_EXT_EN
                    FnXor:  ctrl = CtrlXor;
                    FnNor:  ctrl = CtrlNor;
`endif
                    FnSlt:  ctrl = CtrlSlt;
                    FnSll: begin
                        ctrl = CtrlSll;
                        op0  = rt_data;
                        op1  = {27'b0, shamt};
                    end
                    FnSrl: begin
                        ctrl = CtrlSrl;
                        op0  = rt_data;
                        op1  = {27'b0, shamt};
                    end
                    default: ok = 1'b0;
                endcase
            end
            OpBeq: begin
                ctrl = CtrlSubu;
                dst  = 5'd0;
            end
            OpAddi:  begin ctrl = CtrlAdd;  op1 = simm; dst = rt_f; end
            OpAddiu: begin ctrl = CtrlAddu; op1 = simm; dst = rt_f; end
            OpSlti:  begin ctrl = CtrlSlt;  op1 = simm; dst = rt_f; end
            OpAndi:  begin ctrl = CtrlAnd;  op1 = zimm; dst = rt_f; end
            OpOri:   begin ctrl = CtrlOr;   op1 = zimm; dst = rt_f; end
`ifdef ALU_ISSUER_LOGIC_EXT_EN
            OpXori:  begin ctrl = CtrlXor;  op1 = zimm; dst = rt_f; end
`endif
            default: ok = 1'b0;
        endcase

        dec.control  = ok ? ctrl : CtrlIllegal;
        dec.operand0 = ok ? op0 : 32'h0;
        dec.operand1 = ok ? op1 : 32'h0;
        dec.dest     = ok ? dst : 5'd0;
        dec.illegal  = !ok;
    end

    alu_issue_skid #(
        .entry_t (alu_entry_t)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (in_valid),
        .push_data_i  (dec),
        .push_ready_o (in_ready),
        .pop_valid_o  (out_valid),
        .pop_ready_i  (out_ready),
        .pop_data_o   (head)
    );

    assign accept = in_valid && in_ready;

    // Saturating count of accepted illegal instructions.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (accept && dec.illegal && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    // Illegal counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q <= 8'h00;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign control     = head.control;
    assign operand0    = head.operand0;
    assign operand1    = head.operand1;
    assign dest        = head.dest;
    assign illegal     = head.illegal;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer: the driver pushes hand-computed expected
// entries on acceptance, a monitor pops and compares on every output transfer.
module tb_alu_op_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  control;
    logic [31:0] operand0;
    logic [31:0] operand1;
    logic [4:0]  dest;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic        il;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   accepted = 0;

    always #5 clk = ~clk;

    alu_op_issuer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .control     (control),
        .operand0    (operand0),
        .operand1    (operand1),
        .dest        (dest),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, int fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic exp_t mk(logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                logic [4:0] d, logic il);
        exp_t e;
        e.c = c; e.a = a; e.b = b; e.d = d; e.il = il;
        return e;
    endfunction

    function automatic exp_t ill();
        return mk(4'hF, 32'h0, 32'h0, 5'd0, 1'b1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: ctrl=%h op0=%h op1=%h dest=%0d il=%b",
                         control, operand0, operand1, dest, illegal);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (control !== e.c || operand0 !== e.a || operand1 !== e.b ||
                    dest !== e.d || illegal !== e.il) begin
                    errors++;
                    $display("FAIL issue: got ctrl=%h op0=%h op1=%h dest=%0d il=%b expected ctrl=%h op0=%h op1=%h dest=%0d il=%b",
                             control, operand0, operand1, dest, illegal,
                             e.c, e.a, e.b, e.d, e.il);
                end
            end
        end
    end

    // Present one instruction and hold it until accepted; record expectation on acceptance.
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e);
        bit done = 1'b0;
        instr    = ins;
        rs_data  = a;
        rt_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end
        end
        if (done) begin
            sb.push_back(e);
            accepted++;
            if (e.il && exp_cnt < 255) exp_cnt++;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr %h never accepted", ins);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries still expected", sb.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        exp_t e_xor, e_nor, e_xori;

        // Reset state
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_control", {28'b0, control}, 32'd0);
        check("rst_operand0", operand0, 32'd0);
        check("rst_operand1", operand1, 32'd0);
        check("rst_dest", {27'b0, dest}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_illegal_cnt", {24'b0, illegal_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1 check("ready_after_edge", {31'b0, in_ready}, 32'd1);

        // Directed decode vectors
        out_ready = 1'b1;
        send(rtype(1, 2, 3, 0, 'h20), 32'h7FFFFFFF, 32'h1,
             mk(4'b1011, 32'h7FFFFFFF, 32'h1, 5'd3, 1'b0));
        check("latency_valid", {31'b0, out_valid}, 32'd1);
        check("latency_control", {28'b0, control}, 32'hB);
        send(itype('h08, 4, 5, 'hFFFC), 32'd10, 32'h55,
             mk(4'b1011, 32'd10, 32'hFFFFFFFC, 5'd5, 1'b0));
        send(itype('h0C, 4, 6, 'hFFFC), 32'h1234, 32'h55,
             mk(4'b0000, 32'h1234, 32'h0000FFFC, 5'd6, 1'b0));
        send(rtype(0, 7, 2, 4, 'h00), 32'hDEAD, 32'h1,
             mk(4'b1000, 32'h1, 32'h4, 5'd2, 1'b0));
        send(rtype(0, 9, 8, 31, 'h02), 32'hDEAD, 32'h80000000,
             mk(4'b1001, 32'h80000000, 32'd31, 5'd8, 1'b0));
        send(itype('h04, 1, 2, 'h0010), 32'h11, 32'h22,
             mk(4'b0110, 32'h11, 32'h22, 5'd0, 1'b0));
        send(rtype(3, 4, 31, 0, 'h22), 32'h5, 32'h6, mk(4'b1100, 32'h5, 32'h6, 5'd31, 1'b0));
        send(rtype(3, 4, 10, 0, 'h23), 32'h7, 32'h8, mk(4'b0110, 32'h7, 32'h8, 5'd10, 1'b0));
        send(rtype(3, 4, 11, 0, 'h21), 32'h9, 32'hA, mk(4'b0010, 32'h9, 32'hA, 5'd11, 1'b0));
        send(rtype(3, 4, 12, 0, 'h25), 32'hB, 32'hC, mk(4'b0001, 32'hB, 32'hC, 5'd12, 1'b0));
        send(rtype(3, 4, 13, 0, 'h2A), 32'hD, 32'hE, mk(4'b0111, 32'hD, 32'hE, 5'd13, 1'b0));
        send(rtype(3, 4, 14, 0, 'h24), 32'hF, 32'h10, mk(4'b0000, 32'hF, 32'h10, 5'd14, 1'b0));
        send(itype('h0A, 2, 15, 'h8000), 32'h3, 32'h0,
             mk(4'b0111, 32'h3, 32'hFFFF8000, 5'd15, 1'b0));
        send(itype('h09, 2, 16, 'h7FFF), 32'h3, 32'h0,
             mk(4'b0010, 32'h3, 32'h00007FFF, 5'd16, 1'b0));
        send(itype('h0D, 2, 17, 'h8001), 32'h3, 32'h0,
             mk(4'b0001, 32'h3, 32'h00008001, 5'd17, 1'b0));
        send(rtype(1, 2, 3, 0, 'h3F), 32'h1, 32'h2, ill());
        send(itype('h3F, 1, 2, 'h1234), 32'h1, 32'h2, ill());

        // Optional logic ops
`ifdef ALU_ISSUER_LOGIC_EXT_EN
        e_xor  = mk(4'b0011, 32'hF0, 32'h0F, 5'd18, 1'b0);
        e_nor  = mk(4'b0100, 32'hF0, 32'h0F, 5'd19, 1'b0);
        e_xori = mk(4'b0011, 32'hF0, 32'h0000ABCD, 5'd20, 1'b0);
`else
        e_xor  = ill();
        e_nor  = ill();
        e_xori = ill();
`endif
        send(rtype(1, 2, 18, 0, 'h26), 32'hF0, 32'h0F, e_xor);
        send(rtype(1, 2, 19, 0, 'h27), 32'hF0, 32'h0F, e_nor);
        send(itype('h0E, 1, 20, 'hABCD), 32'hF0, 32'h0F, e_xori);
        drain();
        check("illegal_cnt_mid", {24'b0, illegal_cnt}, exp_cnt);

        // Backpressure: three back-to-back with the output stalled
        out_ready = 1'b0;
        base = accepted;
        fork
            begin
                send(rtype(1, 2, 21, 0, 'h20), 32'h100, 32'h1,
                     mk(4'b1011, 32'h100, 32'h1, 5'd21, 1'b0));
                send(rtype(1, 2, 22, 0, 'h25), 32'h200, 32'h2,
                     mk(4'b0001, 32'h200, 32'h2, 5'd22, 1'b0));
                send(rtype(1, 2, 23, 0, 'h24), 32'h300, 32'h3,
                     mk(4'b0000, 32'h300, 32'h3, 5'd23, 1'b0));
            end
        join_none
        repeat (6) @(posedge clk);
        #2;
        check("bp_accepted", accepted - base, 32'd2);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #2;
        check("bp_hold_operand0", operand0, 32'h100);
        check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int n = 0; n < 100 && (accepted - base) < 3; n++) @(posedge clk);
        check("bp_all_accepted", accepted - base, 32'd3);
        drain();

        // Illegal flood saturates the counter
        for (int i = 0; i < 300; i++) begin
            send(itype('h3F, i % 32, (i + 1) % 32, i), i, ~i, ill());
        end
        drain();
        check("illegal_cnt_sat", {24'b0, illegal_cnt}, 32'd255);

        // Reset with two entries buffered
        out_ready = 1'b0;
        send(rtype(1, 2, 24, 0, 'h20), 32'hAA, 32'hBB, mk(4'b1011, 32'hAA, 32'hBB, 5'd24, 1'b0));
        send(rtype(1, 2, 25, 0, 'h25), 32'hCC, 32'hDD, mk(4'b0001, 32'hCC, 32'hDD, 5'd25, 1'b0));
        #2;
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_illegal_cnt", {24'b0, illegal_cnt}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("mid_rst_operand0", operand0, 32'd0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("no_stale_valid", {31'b0, out_valid}, 32'd0);
        send(itype('h08, 6, 26, 'h0001), 32'h40, 32'h0, mk(4'b1011, 32'h40, 32'h1, 5'd26, 1'b0));
        drain();
        check("post_rst_illegal_cnt", {24'b0, illegal_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
